// File: rtl/mux16_scan_sequencer.sv
// Scan sequencer for the 16x1 mux tree: steps sel through the channels, samples mux_out
// after each dwell and hands out a 16-bit snapshot. Optional channel masking: MUX_SCAN_MASK_EN.
module mux16_scan_sequencer #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic [15:0] chan_mask,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic [15:0] snap_data,
  output logic        snap_valid,
  input  logic        snap_ready,
  output logic        busy
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   shadow, shadow_n;
  logic [3:0]    sel_n;
  logic [15:0]   data_n;
  logic          valid_n;
  logic [15:0]   en, en_start;
  logic [3:0]    first_ch, next_ch;
  logic          is_last;

`ifdef MUX_SCAN_MASK_EN
  logic [15:0] mask_q, mask_n;
  assign en_start = chan_mask;
  assign en       = mask_q;
`else
  logic unused_mask;
  assign unused_mask = ^chan_mask;
  assign en_start    = 16'hFFFF;
  assign en          = 16'hFFFF;
`endif

  // Descending walk so the lowest qualifying channel wins.
  always_comb begin
    first_ch = '0;
    next_ch  = sel;
    is_last  = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      if (en_start[i]) first_ch = 4'(i);
      if (en[i] && (4'(i) > sel)) begin
        next_ch = 4'(i);
        is_last = 1'b0;
      end
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    cnt_n    = cnt;
    shadow_n = shadow;
    data_n   = snap_data;
    valid_n  = snap_valid;
`ifdef MUX_SCAN_MASK_EN
    mask_n   = mask_q;
`endif
    case (state)
      IDLE: begin
        if (start && (|en_start)) begin
          state_n  = SCAN;
          sel_n    = first_ch;
          cnt_n    = '0;
          shadow_n = '0;
`ifdef MUX_SCAN_MASK_EN
          mask_n   = chan_mask;
`endif
        end
      end
      SCAN: begin
        if (cnt == CMAX) begin
          shadow_n[sel] = mux_out;
          cnt_n         = '0;
          if (is_last) begin
            data_n  = shadow_n;
            valid_n = 1'b1;
            state_n = HOLD;
          end else begin
            sel_n = next_ch;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (snap_valid && snap_ready) begin
          valid_n = 1'b0;
          if (cont && (|en_start)) begin
            state_n  = SCAN;
            sel_n    = first_ch;
            cnt_n    = '0;
            shadow_n = '0;
`ifdef MUX_SCAN_MASK_EN
            mask_n   = chan_mask;
`endif
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      sel        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      snap_data  <= '0;
      snap_valid <= 1'b0;
`ifdef MUX_SCAN_MASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state      <= state_n;
      busy       <= (state_n != IDLE);
      sel        <= sel_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      snap_data  <= data_n;
      snap_valid <= valid_n;
`ifdef MUX_SCAN_MASK_EN
      mask_q     <= mask_n;
`endif
    end
  end
endmodule

// File: tb/tb_mux16_scan_sequencer.sv
// Scoreboard bench for mux16_scan_sequencer: directed scans, backpressure, continuous, reset.
module tb_mux16_scan_sequencer;
  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        snap_ready = 1'b0;
  logic [15:0] chan_mask = 16'hFFFF;
  logic [15:0] pattern = 16'h0000;
  logic        mux_out;
  logic [3:0]  sel;
  logic [15:0] snap_data;
  logic        snap_valid;
  logic        busy;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;
  assign mux_out = pattern[sel];

  mux16_scan_sequencer #(.DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .chan_mask(chan_mask),
    .mux_out(mux_out), .sel(sel), .snap_data(snap_data), .snap_valid(snap_valid),
    .snap_ready(snap_ready), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!snap_valid && n < max) begin
      tick();
      n++;
    end
    check("valid_timeout", {31'd0, snap_valid}, 32'd1);
  endtask

  // A handshake completes on the edge after a negedge that sees valid & ready.
  task automatic monitor;
    forever begin
      @(negedge clk);
      if (rst_n && snap_valid && snap_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_snapshot: got %0h expected none", snap_data);
        end else begin
          check("snapshot", {16'd0, snap_data}, {16'd0, sb.pop_front()});
        end
      end
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_sel"},   {28'd0, sel}, 32'd0);
    check({name, "_data"},  {16'd0, snap_data}, 32'd0);
    check({name, "_valid"}, {31'd0, snap_valid}, 32'd0);
    check({name, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int r[3];
    int nr;
    logic pv;
    int n;
    fork
      monitor();
    join_none

    // Reset held two cycles
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single scan, DWELL=4, pattern A5C3
    pattern = 16'hA5C3;
    snap_ready = 1'b1;
    cont = 1'b0;
    sb.push_back(16'hA5C3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 64; c++) begin
      check("sel_step", {28'd0, sel}, c / 4);
      check("busy_scan", {31'd0, busy}, 32'd1);
      check("valid_early", {31'd0, snap_valid}, 32'd0);
      tick();
    end
    check("valid_at_64", {31'd0, snap_valid}, 32'd1);
    check("data_a5c3", {16'd0, snap_data}, 32'h0000A5C3);
    tick();
    check("valid_dropped", {31'd0, snap_valid}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("sel_kept", {28'd0, sel}, 32'd15);

    // Backpressure with ignored start pulses
    snap_ready = 1'b0;
    pattern = 16'h1234;
    sb.push_back(16'h1234);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(100);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      check("bp_data", {16'd0, snap_data}, 32'h00001234);
      check("bp_valid", {31'd0, snap_valid}, 32'd1);
      check("bp_sel", {28'd0, sel}, 32'd15);
      check("bp_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    start = 1'b0;
    snap_ready = 1'b1;
    check("bp_valid_pre", {31'd0, snap_valid}, 32'd1);
    tick();
    check("bp_valid_post", {31'd0, snap_valid}, 32'd0);
    check("bp_busy_post", {31'd0, busy}, 32'd0);

    // Continuous: pattern switches after channel 7 of the second scan
    pattern = 16'hA5C3;
    cont = 1'b1;
    sb.push_back(16'hA5C3);
    sb.push_back(16'h0FC3);
    sb.push_back(16'h0FF0);
    start = 1'b1;
    tick();
    start = 1'b0;
    nr = 0;
    pv = 1'b0;
    r[0] = 0; r[1] = 0; r[2] = 0;
    for (int t = 1; t <= 194; t++) begin
      tick();
      if (t == 97) pattern = 16'h0FF0;
      if (snap_valid && !pv && nr < 3) begin
        r[nr] = t;
        nr++;
      end
      pv = snap_valid;
      if (t == 194) cont = 1'b0;
    end
    check("cont_count", nr, 3);
    check("cont_first", r[0], 64);
    check("cont_period1", r[1] - r[0], 65);
    check("cont_period2", r[2] - r[1], 65);
    tick();
    check("cont_idle", {31'd0, busy}, 32'd0);

    // Reset mid-scan, then a clean scan
    pattern = 16'h5A5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (sel != 4'd9 && n < 200) begin
      tick();
      n++;
    end
    check("reach_sel9", {28'd0, sel}, 32'd9);
    rst_n = 1'b0;
    tick();
    check_zero("midrst1");
    tick();
    check_zero("midrst2");
    rst_n = 1'b1;
    sb.push_back(16'h5A5A);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(100);
    check("post_rst_data", {16'd0, snap_data}, 32'h00005A5A);
    tick();
    check("post_rst_idle", {31'd0, busy}, 32'd0);

`ifdef MUX_SCAN_MASK_EN
    chan_mask = 16'h00F0;
    pattern = 16'hFFFF;
    sb.push_back(16'h00F0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check("mask_sel", {28'd0, sel}, 4 + c / 4);
      check("mask_valid_early", {31'd0, snap_valid}, 32'd0);
      tick();
    end
    check("mask_valid", {31'd0, snap_valid}, 32'd1);
    check("mask_data", {16'd0, snap_data}, 32'h000000F0);
    tick();
    check("mask_idle", {31'd0, busy}, 32'd0);
    chan_mask = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mask0_busy1", {31'd0, busy}, 32'd0);
    tick();
    check("mask0_busy2", {31'd0, busy}, 32'd0);
    chan_mask = 16'hFFFF;
`endif

    tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
